// File: rtl/acc_ctrl_fsm.sv
// acc_ctrl_fsm -- multicycle control unit for the 16-bit accumulator datapath.
//
// Sequences one instruction over 2..5 cycles (FETCH, DECODE, then an
// opcode-specific tail). It drives the ALU operand selects, the ALU
// operation and every register / memory enable.
//
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   Opcode[OP_W-1:0]    IR[15:12], valid from DECODE onward
//   Zero                ALU zero flag (combinational, current cycle)
//   SrcA, SrcB, ALUOP   ALU operand selects and operation
//   AddrSrc             memory address select
//   MemRead, MemWrite   memory strobes
//   IRWrite, MDRWrite, ACCWrite, SPWrite, PCWrite   register enables
//   ACCSrc, PCSrc       write-data selects for ACC and PC
//   Halted              high while in HALT
//   State[3:0]          current state encoding (debug)
//   Illegal             sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//
// Build option: define ILLEGAL_TRAP_EN to trap opcodes >= 12 into HALT and
// expose the Illegal port. Without it an illegal opcode is a 2-cycle NOP.
//
// Handshake: there is no valid/ready protocol; the datapath follows the
// enables cycle by cycle, and Opcode/Zero are sampled without flow control.
module acc_ctrl_fsm #(
    parameter int OP_W = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] Opcode,
    input  logic            Zero,
    output logic [1:0]      SrcA,
    output logic [2:0]      SrcB,
    output logic [2:0]      ALUOP,
    output logic [1:0]      AddrSrc,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MDRWrite,
    output logic            ACCWrite,
    output logic            SPWrite,
    output logic            PCWrite,
    output logic            ACCSrc,
    output logic            PCSrc,
    output logic            Halted,
`ifdef ILLEGAL_TRAP_EN
    output logic            Illegal,
`endif
    output logic [3:0]      State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_RD  = 4'd2,
        S_LD_WB   = 4'd3,
        S_EXEC    = 4'd4,
        S_ALU_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_BR      = 4'd7,
        S_SP_DEC  = 4'd8,
        S_PUSH_WR = 4'd9,
        S_POP_RD  = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] addr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       acc_write;
        logic       sp_write;
        logic       pc_write;
        logic       pc_write_on_zero;  // BEQZ in BR: PCWrite follows Zero
        logic       acc_src;
        logic       pc_src;
        logic       halted;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BEQZ  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_PUSH  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_POP   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = OP_W'(12);

    function automatic state_t next_state(input state_t s, input logic [OP_W-1:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: n = S_MEM_RD;
                    OP_ADDI:           n = S_EXEC;
                    OP_STORE:          n = S_MEM_WR;
                    OP_BEQZ, OP_JUMP:  n = S_BR;
                    OP_PUSH:           n = S_SP_DEC;
                    OP_POP:            n = S_POP_RD;
                    OP_HALT:           n = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:           n = S_HALT;
`else
                    default:           n = S_FETCH;
`endif
                endcase
            end
            S_MEM_RD:  n = (op == OP_LOAD) ? S_LD_WB : S_EXEC;
            S_EXEC:    n = S_ALU_WB;
            S_SP_DEC:  n = S_PUSH_WR;
            S_POP_RD:  n = S_LD_WB;
            S_HALT:    n = S_HALT;
            default:   n = S_FETCH;  // LD_WB, ALU_WB, MEM_WR, BR, PUSH_WR, 12..15
        endcase
        return n;
    endfunction

    // Moore control word for the state being entered. Outputs are registered,
    // so the word is computed from the next state and the current Opcode.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;   // PC <= PC + 2 straight from the ALU
            end
            S_DECODE: begin
                c.src_b = 3'd4;      // PC + (offset << 1) lands in aluOut
            end
            S_MEM_RD: begin
                c.mem_read  = 1'b1;
                c.addr_src  = 2'd1;
                c.mdr_write = 1'b1;
            end
            S_LD_WB: begin
                c.acc_write = 1'b1;
            end
            S_EXEC: begin
                c.src_a = 2'd1;
                c.src_b = (op == OP_ADDI) ? 3'd1 : 3'd2;
                case (op)
                    OP_SUB:  c.alu_op = 3'd1;
                    OP_AND:  c.alu_op = 3'd2;
                    OP_OR:   c.alu_op = 3'd3;
                    default: c.alu_op = 3'd0;
                endcase
            end
            S_ALU_WB: begin
                c.acc_write = 1'b1;
                c.acc_src   = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.addr_src  = 2'd1;
            end
            S_BR: begin
                c.src_a            = 2'd1;
                c.alu_op           = 3'd4;
                c.pc_src           = 1'b1;
                c.pc_write         = (op == OP_JUMP);
                c.pc_write_on_zero = (op == OP_BEQZ);
            end
            S_SP_DEC: begin
                c.src_a    = 2'd2;
                c.alu_op   = 3'd1;
                c.sp_write = 1'b1;
            end
            S_PUSH_WR: begin
                c.mem_write = 1'b1;
                c.addr_src  = 2'd2;
            end
            S_POP_RD: begin
                c.mem_read  = 1'b1;
                c.addr_src  = 2'd2;
                c.mdr_write = 1'b1;
                c.src_a     = 2'd2;
                c.sp_write  = 1'b1;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t w_next;
    state_t r_state;
    ctrl_t  r_ctrl;

    assign w_next = next_state(r_state, Opcode);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH, Opcode);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, Opcode);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE && Opcode >= OP_ILLEGAL_MIN) begin
            r_illegal <= 1'b1;
        end
    end

    assign Illegal = r_illegal;
`endif

    // Strobes are masked by Reset so nothing is written while it is held,
    // even in the cycle before the reset edge is taken.
    assign SrcA     = r_ctrl.src_a;
    assign SrcB     = r_ctrl.src_b;
    assign ALUOP    = r_ctrl.alu_op;
    assign AddrSrc  = r_ctrl.addr_src;
    assign ACCSrc   = r_ctrl.acc_src;
    assign PCSrc    = r_ctrl.pc_src;
    assign MemRead  = r_ctrl.mem_read  & ~Reset;
    assign MemWrite = r_ctrl.mem_write & ~Reset;
    assign IRWrite  = r_ctrl.ir_write  & ~Reset;
    assign MDRWrite = r_ctrl.mdr_write & ~Reset;
    assign ACCWrite = r_ctrl.acc_write & ~Reset;
    assign SPWrite  = r_ctrl.sp_write  & ~Reset;
    assign PCWrite  = (r_ctrl.pc_write | (r_ctrl.pc_write_on_zero & Zero)) & ~Reset;
    assign Halted   = r_ctrl.halted    & ~Reset;
    assign State    = r_state;

endmodule

// File: doc/acc_ctrl_fsm.md
Name: acc_ctrl_fsm

Overview:
- Multicycle control unit for the 16-bit accumulator datapath.
- Drives the ALU source selects (SrcA, SrcB), ALUOP, and all register and memory enables.
- Consumes the ALU Zero flag and the instruction opcode.
- Sits opposite the ALU subsystem: that block executes, this block sequences one instruction over 3–5 cycles.

Parameters:
- OP_W, 4, opcode field width; opcodes at or above 12 are illegal.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  OP_W  IR[15:12], valid from DECODE onward.
- Zero  in  1  ALU Zero flag, combinational from the current cycle.
- SrcA  out  2  0=PC, 1=ACC, 2=SP.
- SrcB  out  3  0=const 2, 1=SE, 2=MDR, 3=ZE, 4=SL1.
- ALUOP  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=PASS_A.
- AddrSrc  out  2  memory address: 0=PC, 1=ZE, 2=SP.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite, MDRWrite, ACCWrite, SPWrite, PCWrite  out  1 each  register enables.
- ACCSrc  out  1  0=MDR, 1=aluOut register.
- PCSrc  out  1  0=ALU Out (combinational), 1=aluOut register.
- Halted  out  1  high in HALT state.
- State  out  4  current state encoding, for debug.

Behaviour:
- Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 ADDI, 7 BEQZ, 8 JUMP, 9 PUSH, 10 POP, 11 HALT.
- Unlisted outputs are 0 in every state. SrcA, SrcB, ALUOP and AddrSrc are 0 when not listed.
- Outputs are Moore, except PCWrite in BR, which is Mealy on Zero.
- Reset: while Reset is high, all enables and strobes are 0 and Halted=0. On the next edge the state is FETCH. Reset mid-instruction aborts it with no partial writes after that edge.
- State encodings 0–11: FETCH, DECODE, MEM_RD, LD_WB, EXEC, ALU_WB, MEM_WR, BR, SP_DEC, PUSH_WR, POP_RD, HALT.
- FETCH (0): MemRead, AddrSrc=PC, IRWrite, SrcA=PC, SrcB=2(const), ALUOP=ADD, PCWrite, PCSrc=0. Next: DECODE.
- DECODE (1): SrcA=PC, SrcB=SL1, ALUOP=ADD. This precomputes the branch target into aluOut. Next by opcode:
  - LOAD/ADD/SUB/AND/OR → MEM_RD
  - ADDI → EXEC
  - STORE → MEM_WR
  - BEQZ/JUMP → BR
  - PUSH → SP_DEC
  - POP → POP_RD
  - HALT → HALT
- MEM_RD (2): MemRead, AddrSrc=ZE, MDRWrite. Next: LD_WB if LOAD, else EXEC.
- LD_WB (3): ACCWrite, ACCSrc=0. Next: FETCH.
- EXEC (4): SrcA=ACC. SrcB=SE for ADDI, MDR otherwise. ALUOP: ADD for ADD/ADDI, SUB for SUB, AND for AND, OR for OR. Next: ALU_WB.
- ALU_WB (5): ACCWrite, ACCSrc=1. Next: FETCH.
- MEM_WR (6): MemWrite, AddrSrc=ZE. Next: FETCH.
- BR (7): SrcA=ACC, ALUOP=PASS_A, PCSrc=1. PCWrite=1 for JUMP; PCWrite=Zero for BEQZ. Next: FETCH.
- SP_DEC (8): SrcA=SP, SrcB=const 2, ALUOP=SUB, SPWrite. Next: PUSH_WR.
- PUSH_WR (9): MemWrite, AddrSrc=SP (already decremented). Next: FETCH.
- POP_RD (10): MemRead, AddrSrc=SP, MDRWrite, SrcA=SP, SrcB=const 2, ALUOP=ADD, SPWrite. Next: LD_WB.
- HALT (11): Halted=1, no writes. Stays in HALT until Reset.
- Cycle counts per instruction:
  - STORE, BEQZ, JUMP: 3
  - LOAD, ADDI, PUSH, POP: 4
  - ADD, SUB, AND, OR: 5
- MemRead and MemWrite are never high in the same cycle.
- Unreachable state encodings 12–15 go to FETCH on the next edge with no writes.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT. An extra output port Illegal (1 bit) is set there and cleared only by Reset.
- Undefined: an illegal opcode is a NOP (DECODE → FETCH, 2 cycles). No Illegal port exists.

Test Plan:
- Reset held 2 cycles mid-EXEC → all enables 0 during reset; State=0 (FETCH) the cycle after release; no ACCWrite.
- LOAD (op 0) → States 0,1,2,3,0. MemRead with AddrSrc=1 in MEM_RD. ACCWrite with ACCSrc=0 in cycle 4.
- ADD (op 2) then ADDI (op 6) → EXEC shows SrcB=2 then SrcB=1, ALUOP=0. ACCWrite with ACCSrc=1 in ALU_WB. Durations 5 and 4 cycles.
- BEQZ (op 7) with Zero=1, then repeated with Zero=0 → PCWrite=1 with PCSrc=1 in BR only for Zero=1. JUMP (op 8) with Zero=0 → PCWrite=1.
- PUSH (op 9) then POP (op 10) → SP_DEC has ALUOP=1 and SPWrite, then PUSH_WR has MemWrite with AddrSrc=2. POP_RD has MemRead, MDRWrite, SPWrite and ALUOP=0, then LD_WB.
- HALT (op 11) → Halted=1, State=11, no enables for 20 cycles, exits only on Reset. Opcode 13 with ILLEGAL_TRAP_EN → HALT and Illegal=1; without it → DECODE→FETCH.
